matmul_sequencer: RTL and testbench

MATMUL_SEQUENCER -- requirements
Module: matmul_sequencer

---
 rtl/matmul_pkg.sv | 26 ++
 rtl/matmul_sequencer.sv | 178 +++++++++++++++++
 tb/tb_matmul_sequencer.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/matmul_pkg.sv
// Shared types and parameters for the systolic-array command sequencer.
package matmul_pkg;

    localparam int unsigned DimDefault = 8;

    // Latency for a DIM x DIM output-stationary array: skew in, compute, drain.
    function automatic int unsigned lat_of(input int unsigned dim);
        return 3 * dim - 2;
    endfunction

    typedef enum logic [2:0] {
        OpLoadA   = 3'b000,
        OpLoadB   = 3'b001,
        OpLoadC   = 3'b010,
        OpCompute = 3'b011,
        OpReadC   = 3'b100
    } op_e;

    typedef enum logic [1:0] {
        StIdle,
        StBusy,
        StDone,
        StRead
    } state_e;

endpackage

// File: rtl/matmul_sequencer.sv
// Sequences execute-stage matmul commands onto a systolic array: element loads,
// a fixed-latency compute and single-element result reads.
module matmul_sequencer
    import matmul_pkg::*;
#(
    parameter int unsigned DIM = DimDefault,
    parameter int unsigned LAT = lat_of(DIM)
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        flush_i,
    input  logic        cmd_valid_i,
    input  logic [2:0]  cmd_op_i,
    input  logic [4:0]  cmd_row_i,
    input  logic [4:0]  cmd_col_i,
    input  logic [31:0] cmd_data_i,
    output logic        cmd_ready_o,
    output logic        stall_o,
    output logic        sa_write_enable_A_o,
    output logic        sa_write_enable_B_o,
    output logic        sa_write_enable_C_o,
    output logic [4:0]  sa_row_o,
    output logic [4:0]  sa_col_o,
    output logic [31:0] sa_data_o,
    output logic        sa_start_o,
    input  logic [31:0] sa_cout_i,
    output logic [31:0] result_o,
    output logic        result_valid_o,
    output logic        done_o,
    output logic        err_o
);

    localparam int unsigned CntW = $clog2(LAT + 1);

    state_e            state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic              we_a_q, we_a_d;
    logic              we_b_q, we_b_d;
    logic              we_c_q, we_c_d;
    logic              start_q, start_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic              res_valid_q, res_valid_d;
    logic [4:0]        row_q, row_d;
    logic [4:0]        col_q, col_d;
    logic [31:0]       data_q, data_d;
    logic [31:0]       result_q, result_d;

    logic accept;
    logic in_range;
    logic op_legal;

    assign accept   = cmd_valid_i && (state_q == StIdle) && !flush_i;
    assign in_range = ({27'd0, cmd_row_i} < DIM) && ({27'd0, cmd_col_i} < DIM);
    assign op_legal = (cmd_op_i <= OpReadC);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        we_a_d      = 1'b0;
        we_b_d      = 1'b0;
        we_c_d      = 1'b0;
        start_d     = 1'b0;
        done_d      = 1'b0;
        err_d       = 1'b0;
        res_valid_d = 1'b0;
        row_d       = row_q;
        col_d       = col_q;
        data_d      = data_q;
        result_d    = result_q;

        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    if (!in_range || !op_legal) begin
                        err_d = 1'b1;
                    end else begin
                        case (cmd_op_i)
                            OpLoadA, OpLoadB, OpLoadC: begin
                                we_a_d = (cmd_op_i == OpLoadA);
                                we_b_d = (cmd_op_i == OpLoadB);
                                we_c_d = (cmd_op_i == OpLoadC);
                                row_d  = cmd_row_i;
                                col_d  = cmd_col_i;
                                data_d = cmd_data_i;
                            end
                            OpCompute: begin
                                state_d = StBusy;
                                cnt_d   = CntW'(LAT);
                                start_d = 1'b1;
                            end
                            OpReadC: begin
                                state_d = StRead;
                                row_d   = cmd_row_i;
                                col_d   = cmd_col_i;
                            end
                            default: ;
                        endcase
                    end
                end
            end
            StBusy: begin
                if (flush_i) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end else if (cnt_q == CntW'(1)) begin
                    state_d = StDone;
                    cnt_d   = '0;
                    done_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q - CntW'(1);
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            StRead: begin
                state_d = StIdle;
                // A flushed read leaves the previous result visible.
                if (!flush_i) begin
                    result_d    = sa_cout_i;
                    res_valid_d = 1'b1;
                end
            end
            default: begin
                state_d = StIdle;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            we_a_q      <= 1'b0;
            we_b_q      <= 1'b0;
            we_c_q      <= 1'b0;
            start_q     <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            res_valid_q <= 1'b0;
            row_q       <= '0;
            col_q       <= '0;
            data_q      <= '0;
            result_q    <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            we_a_q      <= we_a_d;
            we_b_q      <= we_b_d;
            we_c_q      <= we_c_d;
            start_q     <= start_d;
            done_q      <= done_d;
            err_q       <= err_d;
            res_valid_q <= res_valid_d;
            row_q       <= row_d;
            col_q       <= col_d;
            data_q      <= data_d;
            result_q    <= result_d;
        end
    end

    assign cmd_ready_o         = (state_q == StIdle);
    assign stall_o             = (state_q == StBusy) || (state_q == StRead);
    assign sa_write_enable_A_o = we_a_q;
    assign sa_write_enable_B_o = we_b_q;
    assign sa_write_enable_C_o = we_c_q;
    assign sa_row_o            = row_q;
    assign sa_col_o            = col_q;
    assign sa_data_o           = data_q;
    assign sa_start_o          = start_q;
    assign result_o            = result_q;
    assign result_valid_o      = res_valid_q;
    assign done_o              = done_q;
    assign err_o               = err_q;

endmodule

// File: tb/tb_matmul_sequencer.sv
// Directed bench for matmul_sequencer at DIM=8 (LAT=22), hand-computed expectations.
module tb_matmul_sequencer;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        cmd_valid;
    logic [2:0]  cmd_op;
    logic [4:0]  cmd_row;
    logic [4:0]  cmd_col;
    logic [31:0] cmd_data;
    logic        cmd_ready;
    logic        stall;
    logic        we_a, we_b, we_c;
    logic [4:0]  sa_row, sa_col;
    logic [31:0] sa_data;
    logic        sa_start;
    logic [31:0] sa_cout;
    logic [31:0] result;
    logic        result_valid;
    logic        done;
    logic        err;

    int n_vec;
    int n_bad;

    matmul_sequencer dut (
        .clk_i               (clk),
        .rst_n_i             (rst_n),
        .flush_i             (flush),
        .cmd_valid_i         (cmd_valid),
        .cmd_op_i            (cmd_op),
        .cmd_row_i           (cmd_row),
        .cmd_col_i           (cmd_col),
        .cmd_data_i          (cmd_data),
        .cmd_ready_o         (cmd_ready),
        .stall_o             (stall),
        .sa_write_enable_A_o (we_a),
        .sa_write_enable_B_o (we_b),
        .sa_write_enable_C_o (we_c),
        .sa_row_o            (sa_row),
        .sa_col_o            (sa_col),
        .sa_data_o           (sa_data),
        .sa_start_o          (sa_start),
        .sa_cout_i           (sa_cout),
        .result_o            (result),
        .result_valid_o      (result_valid),
        .done_o              (done),
        .err_o               (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Array read model: only element (2,7) holds 0x1234.
    assign sa_cout = (sa_row == 5'd2 && sa_col == 5'd7) ? 32'h0000_1234 : 32'h0000_BAD0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [2:0] op, input logic [4:0] row, input logic [4:0] col,
                        input logic [31:0] data);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_row   = row;
        cmd_col   = col;
        cmd_data  = data;
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic count_done(input int cycles, output int n_done, output int n_rv);
        n_done = 0;
        n_rv   = 0;
        for (int i = 0; i < cycles; i++) begin
            if (done) n_done++;
            if (result_valid) n_rv++;
            tick();
        end
    endtask

    int stall_cnt, start_cnt, done_cnt, done_at, wea_cnt, rv_cnt;

    initial begin
        n_vec     = 0;
        n_bad     = 0;
        rst_n     = 1'b0;
        flush     = 1'b0;
        cmd_valid = 1'b0;
        cmd_op    = 3'd0;
        cmd_row   = 5'd0;
        cmd_col   = 5'd0;
        cmd_data  = 32'd0;
        tick();
        tick();
        check_eq("rst_ready", 32'(cmd_ready), 32'd1);
        check_eq("rst_stall", 32'(stall), 32'd0);
        check_eq("rst_result", result, 32'd0);
        check_eq("rst_sa_data", sa_data, 32'd0);
        rst_n = 1'b1;
        tick();

        // Loads, including back-to-back
        send(3'b000, 5'd3, 5'd5, 32'hDEAD_BEEF);
        check_eq("loadA_we", {29'd0, we_a, we_b, we_c}, 32'b100);
        check_eq("loadA_row", 32'(sa_row), 32'd3);
        check_eq("loadA_col", 32'(sa_col), 32'd5);
        check_eq("loadA_data", sa_data, 32'hDEAD_BEEF);
        cmd_valid = 1'b1; cmd_op = 3'b001; cmd_row = 5'd1; cmd_col = 5'd2; cmd_data = 32'h11;
        tick();
        check_eq("loadB_we", {29'd0, we_a, we_b, we_c}, 32'b010);
        cmd_op = 3'b010; cmd_row = 5'd7; cmd_col = 5'd7; cmd_data = 32'h22;
        tick();
        cmd_valid = 1'b0;
        check_eq("loadC_we", {29'd0, we_a, we_b, we_c}, 32'b001);
        check_eq("loadC_addr", {22'd0, sa_row, sa_col}, {22'd0, 5'd7, 5'd7});
        check_eq("loadC_data", sa_data, 32'h22);
        tick();
        check_eq("load_pulse_drop", {29'd0, we_a, we_b, we_c}, 32'b000);

        // Out-of-range and illegal op
        send(3'b001, 5'd8, 5'd0, 32'h33);
        check_eq("oor_err", 32'(err), 32'd1);
        check_eq("oor_we", {29'd0, we_a, we_b, we_c}, 32'b000);
        check_eq("oor_data_kept", sa_data, 32'h22);
        tick();
        check_eq("err_pulse_drop", 32'(err), 32'd0);
        send(3'b101, 5'd0, 5'd0, 32'h0);
        check_eq("illop_err", 32'(err), 32'd1);
        check_eq("illop_idle", {30'd0, cmd_ready, stall}, 32'b10);
        tick();

        // Compute: start pulse, 22 stall cycles, done in cycle 23; commands during BUSY ignored
        send(3'b011, 5'd0, 5'd0, 32'h0);
        stall_cnt = 0; start_cnt = 0; done_cnt = 0; done_at = 0; wea_cnt = 0;
        for (int c = 1; c <= 40; c++) begin
            if (stall) stall_cnt++;
            if (sa_start) start_cnt++;
            if (we_a) wea_cnt++;
            if (done) begin
                done_cnt++;
                done_at = c;
                check_eq("done_no_stall", 32'(stall), 32'd0);
            end
            cmd_valid = stall;
            cmd_op    = 3'b000;
            tick();
        end
        cmd_valid = 1'b0;
        check_eq("cmp_stall_cycles", 32'(stall_cnt), 32'd22);
        check_eq("cmp_start_cnt", 32'(start_cnt), 32'd1);
        check_eq("cmp_done_cnt", 32'(done_cnt), 32'd1);
        check_eq("cmp_done_at", 32'(done_at), 32'd23);
        check_eq("cmp_busy_ignored", 32'(wea_cnt), 32'd0);

        // Read C (2,7)
        send(3'b100, 5'd2, 5'd7, 32'h0);
        check_eq("rd_stall", 32'(stall), 32'd1);
        check_eq("rd_addr", {22'd0, sa_row, sa_col}, {22'd0, 5'd2, 5'd7});
        check_eq("rd_rv_early", 32'(result_valid), 32'd0);
        tick();
        check_eq("rd_result", result, 32'h0000_1234);
        check_eq("rd_rv", 32'(result_valid), 32'd1);
        check_eq("rd_idle", {30'd0, cmd_ready, stall}, 32'b10);
        tick();
        check_eq("rd_rv_drop", 32'(result_valid), 32'd0);

        // Flush at BUSY cycle 10
        send(3'b011, 5'd0, 5'd0, 32'h0);
        repeat (9) tick();
        check_eq("fl_busy", 32'(stall), 32'd1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check_eq("fl_idle", {30'd0, cmd_ready, stall}, 32'b10);
        count_done(30, done_cnt, rv_cnt);
        check_eq("fl_no_done", 32'(done_cnt), 32'd0);

        // Flush during READ keeps old result
        send(3'b100, 5'd1, 5'd1, 32'h0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check_eq("flrd_rv", 32'(result_valid), 32'd0);
        check_eq("flrd_result", result, 32'h0000_1234);
        check_eq("flrd_ready", 32'(cmd_ready), 32'd1);

        // Flush with a command present: flush wins
        flush = 1'b1;
        send(3'b010, 5'd1, 5'd1, 32'h44);
        check_eq("flcmd_we", {29'd0, we_a, we_b, we_c}, 32'b000);
        check_eq("flcmd_err", 32'(err), 32'd0);
        send(3'b110, 5'd0, 5'd0, 32'h0);
        flush = 1'b0;
        check_eq("flill_err", 32'(err), 32'd0);

        // Asynchronous reset in the first BUSY cycle
        send(3'b011, 5'd0, 5'd0, 32'h0);
        check_eq("ar_start_pre", 32'(sa_start), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("ar_ready", 32'(cmd_ready), 32'd1);
        check_eq("ar_stall", 32'(stall), 32'd0);
        check_eq("ar_pulses", {27'd0, sa_start, done, err, result_valid, we_a}, 32'd0);
        check_eq("ar_result", result, 32'd0);
        tick();
        rst_n = 1'b1;
        count_done(30, done_cnt, rv_cnt);
        check_eq("ar_no_done", 32'(done_cnt), 32'd0);

        // Asynchronous reset mid-READ
        send(3'b100, 5'd2, 5'd7, 32'h0);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("arrd_stall", 32'(stall), 32'd0);
        tick();
        rst_n = 1'b1;
        count_done(5, done_cnt, rv_cnt);
        check_eq("arrd_no_rv", 32'(rv_cnt), 32'd0);
        check_eq("arrd_result", result, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
